// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-way registered multiplexer/arbiter.
package mux_arb_pkg;

   localparam logic MODE_EXPLICIT = 1'b0;
   localparam logic MODE_RR       = 1'b1;
   localparam int   MAX_INPUTS    = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [MAX_INPUTS-1:0] onehot(input int idx);
      logic [MAX_INPUTS-1:0] v;
      v = '0;
      if (idx >= 0 && idx < MAX_INPUTS) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter_nway.sv
// Combinational round-robin picker: scans req from ptr with wrap; a locked,
// still-requesting previous winner (the index just below ptr) wins outright.
module rr_arbiter_nway
   import mux_arb_pkg::*;
#(
   parameter int INPUTS = 8,
   parameter int SEL_W  = clog2(INPUTS)
) (
   input  logic [INPUTS-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic [INPUTS-1:0] lock,
   output logic [SEL_W-1:0]  winner,
   output logic              found
);

   int prev;
   int idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      prev   = (ptr == '0) ? INPUTS - 1 : int'(ptr) - 1;
      idx    = 0;
      if (lock[prev] && req[prev]) begin
         winner = SEL_W'(prev);
         found  = 1'b1;
      end
      for (int k = 0; k < INPUTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= INPUTS) idx = idx - INPUTS;
         if (!found && req[idx]) begin
            winner = SEL_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_nway.sv
// N-input registered mux with valid/ready output and explicit or round-robin selection.
// Optional burst locking in round-robin mode is enabled by defining MUX_ARB_LOCK_EN.
module mux_arb_nway
   import mux_arb_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int INPUTS = 8,
   parameter int SEL_W  = clog2(INPUTS)
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic [WIDTH*INPUTS-1:0]   In,
   input  logic [INPUTS-1:0]         Req,
   input  logic [SEL_W-1:0]          Op,
   input  logic                      Mode,
`ifdef MUX_ARB_LOCK_EN
   input  logic [INPUTS-1:0]         Lock,
`endif
   output logic [INPUTS-1:0]         Grant,
   output logic [WIDTH-1:0]          Output,
   output logic [SEL_W-1:0]          Out_Sel,
   output logic                      Out_Valid,
   input  logic                      Out_Ready
);

   localparam int EXT_N = 1 << SEL_W;

   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;
   logic [INPUTS-1:0] lock_eff;
   logic [SEL_W-1:0]  rr_winner;
   logic              rr_found;
   logic [EXT_N-1:0]  req_ext;
   logic [SEL_W-1:0]  win;
   logic              hit;
   logic              acc;
   logic              grant_en;
   int                sel_int;

`ifdef MUX_ARB_LOCK_EN
   logic rr_won_q, rr_won_d;
   // Ptr-1 only names a real previous winner once a round-robin grant has happened.
   assign lock_eff = rr_won_q ? Lock : '0;
`else
   assign lock_eff = '0;
`endif

   rr_arbiter_nway #(
      .INPUTS (INPUTS),
      .SEL_W  (SEL_W)
   ) u_rr (
      .req    (Req),
      .ptr    (ptr_q),
      .lock   (lock_eff),
      .winner (rr_winner),
      .found  (rr_found)
   );

   always_comb begin
      acc     = !valid_q || Out_Ready;
      req_ext = EXT_N'(Req);
      if (Mode == MODE_RR) begin
         win = rr_winner;
         hit = rr_found;
      end else begin
         // Padding bits of req_ext are zero, so Op >= INPUTS never hits.
         win = Op;
         hit = req_ext[Op];
      end
      grant_en = acc && hit && !Reset;
      Grant    = grant_en ? INPUTS'(onehot(int'(win))) : '0;
      sel_int  = grant_en ? int'(win) : 0;

      ptr_d   = ptr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
`ifdef MUX_ARB_LOCK_EN
      rr_won_d = rr_won_q;
`endif
      if (grant_en) begin
         data_d  = In[sel_int*WIDTH +: WIDTH];
         sel_d   = win;
         valid_d = 1'b1;
         if (Mode == MODE_RR) begin
            ptr_d = (win == SEL_W'(INPUTS - 1)) ? '0 : win + 1'b1;
`ifdef MUX_ARB_LOCK_EN
            rr_won_d = 1'b1;
`endif
         end
      end else if (Out_Ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         ptr_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
`ifdef MUX_ARB_LOCK_EN
         rr_won_q <= 1'b0;
`endif
      end else begin
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
`ifdef MUX_ARB_LOCK_EN
         rr_won_q <= rr_won_d;
`endif
      end
   end

   assign Output    = data_q;
   assign Out_Sel   = sel_q;
   assign Out_Valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nway.sv
// Scoreboard bench for mux_arb_nway: an 8-input instance with a reference model
// and a 6-input instance for out-of-range explicit selects.
module tb_mux_arb_nway;
   import mux_arb_pkg::*;

`ifdef MUX_ARB_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] src [8] = '{16'd235, 16'd2346, 16'd134, 16'd2376,
                            16'd768, 16'd876, 16'd2457, 16'd456};
   logic [127:0] in8;
   logic [7:0]  req, lock, grant;
   logic [2:0]  op, out_sel;
   logic        mode, ready, out_valid;
   logic [15:0] out_data;

   logic [95:0] in6;
   logic [5:0]  req6, lock6, grant6;
   logic [2:0]  op6, sel6;
   logic        mode6, ready6, valid6;
   logic [15:0] out6;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 8; i++) in8[i*16 +: 16] = src[i];
      for (int i = 0; i < 6; i++) in6[i*16 +: 16] = src[i];
   end

   mux_arb_nway #(.WIDTH(16), .INPUTS(8)) dut8 (
      .CLK(clk), .Reset(rst), .In(in8), .Req(req), .Op(op), .Mode(mode),
`ifdef MUX_ARB_LOCK_EN
      .Lock(lock),
`endif
      .Grant(grant), .Output(out_data), .Out_Sel(out_sel),
      .Out_Valid(out_valid), .Out_Ready(ready)
   );

   mux_arb_nway #(.WIDTH(16), .INPUTS(6)) dut6 (
      .CLK(clk), .Reset(rst), .In(in6), .Req(req6), .Op(op6), .Mode(mode6),
`ifdef MUX_ARB_LOCK_EN
      .Lock(lock6),
`endif
      .Grant(grant6), .Output(out6), .Out_Sel(sel6),
      .Out_Valid(valid6), .Out_Ready(ready6)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   typedef struct { int sel; logic [15:0] data; } word_t;
   word_t sb [$];
   int    m_ptr = 0;
   int    m_last = -1;
   bit    m_valid = 1'b0;
   bit    m_after_rst = 1'b0;
   logic [7:0] seen_grant;

   // One clock of the 8-input instance: check against the model, then advance it.
   task automatic cycle(input string tag);
      int    w;
      bit    locked;
      word_t e;
      #1;
      if (m_after_rst) begin
         check({tag, "_rst_out"}, 32'(out_data), 32'd0);
         check({tag, "_rst_sel"}, 32'(out_sel), 32'd0);
      end
      check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
      w = -1;
      locked = 1'b0;
      if (!rst && (!m_valid || ready)) begin
         if (mode == MODE_EXPLICIT) begin
            if (req[op]) w = int'(op);
         end else if (LOCK_ON && m_last >= 0 && lock[m_last] && req[m_last]) begin
            w = m_last;
            locked = 1'b1;
         end else begin
            for (int k = 0; k < 8; k++) begin
               if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
            end
         end
      end
      seen_grant = grant;
      check({tag, "_grant"}, 32'(grant), (w >= 0) ? 32'(onehot(w)) : 32'd0);
      if (m_valid && !rst) begin
         check({tag, "_sb_size"}, 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = ready ? sb.pop_front() : sb[0];
            check({tag, "_data"}, 32'(out_data), 32'(e.data));
            check({tag, "_sel"}, 32'(out_sel), 32'(e.sel));
         end
      end
      if (w >= 0) begin
         e.sel = w;
         e.data = src[w];
         sb.push_back(e);
      end
      if (rst) begin
         m_valid = 1'b0;
         sb.delete();
         m_ptr = 0;
         m_last = -1;
      end else if (w >= 0) begin
         m_valid = 1'b1;
         if (mode == MODE_RR) begin
            if (!locked) m_ptr = (w + 1) % 8;
            m_last = w;
         end
      end else if (ready) begin
         m_valid = 1'b0;
      end
      m_after_rst = rst;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int rr_order [6] = '{0, 2, 5, 7, 0, 2};
      rst = 1'b1; req = '0; op = '0; mode = MODE_EXPLICIT; ready = 1'b1; lock = '0;
      req6 = '0; op6 = '0; mode6 = MODE_EXPLICIT; ready6 = 1'b1; lock6 = '0;
      @(negedge clk);
      @(negedge clk);
      cycle("reset");
      rst = 1'b0;
      cycle("idle");

      // Out-of-range explicit select on the 6-input instance
      req6 = 6'h3F; op6 = 3'd5;
      #1 check("oor_grant5", 32'(grant6), 32'h20);
      @(posedge clk); #1;
      check("oor_valid5", 32'(valid6), 32'd1);
      check("oor_data5", 32'(out6), 32'(src[5]));
      check("oor_sel5", 32'(sel6), 32'd5);
      op6 = 3'd7;
      #1 check("oor_grant7", 32'(grant6), 32'd0);
      @(posedge clk); #1;
      check("oor_valid_drop", 32'(valid6), 32'd0);
      check("oor_data_keep", 32'(out6), 32'(src[5]));
      op6 = 3'd6;
      #1 check("oor_grant6", 32'(grant6), 32'd0);
      req6 = '0;
      @(negedge clk);
      cycle("idle2");

      // Explicit select stepping Op
      mode = MODE_EXPLICIT; req = 8'hFF; ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         cycle("explicit");
      end
      req = '0;
      cycle("explicit_drain");
      cycle("explicit_idle");

      // Round-robin over a sparse request vector
      mode = MODE_RR; req = 8'b1010_0101;
      for (int i = 0; i < 6; i++) begin
         cycle("rr");
         check("rr_order", 32'(seen_grant), 32'(onehot(rr_order[i])));
      end
      req = '0;
      cycle("rr_drain");
      cycle("rr_idle");

      // Backpressure holds the first word
      mode = MODE_EXPLICIT; req = 8'hFF; op = 3'd0; ready = 1'b1;
      cycle("bp_first");
      ready = 1'b0; op = 3'd1;
      for (int i = 0; i < 5; i++) begin
         cycle("bp_hold");
         check("bp_hold_grant", 32'(seen_grant), 32'd0);
         check("bp_hold_235", 32'(out_data), 32'd235);
      end
      ready = 1'b1;
      cycle("bp_release");
      req = '0;
      cycle("bp_drain");
      cycle("bp_idle");

      // Reset while a word is pending and stalled
      op = 3'd3; req = 8'hFF; ready = 1'b1;
      cycle("rst_load");
      ready = 1'b0; rst = 1'b1;
      cycle("rst_mid");
      rst = 1'b0; ready = 1'b1; mode = MODE_RR; req = 8'b0100_1010;
      cycle("rst_after");
      check("rst_first_rr", 32'(seen_grant), 32'h02);
      req = '0;
      cycle("rst_drain");

      if (LOCK_ON) begin
         mode = MODE_RR; req = 8'b0000_1100; lock = 8'b0000_0100;
         for (int i = 0; i < 4; i++) begin
            cycle("lock");
            check("lock_src2", 32'(seen_grant), 32'h04);
         end
         lock = '0;
         cycle("unlock");
         check("unlock_src3", 32'(seen_grant), 32'h08);
         req = '0;
         cycle("lock_drain");
      end

      cycle("final_idle");
      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
